// File: rtl/ucup_mem_pkg.sv
// rtl/ucup_mem_pkg.sv - shared types and widths for the uCup external memory bridge
package ucup_mem_pkg;

    localparam int MemAddrW    = 32;
    localparam int MemDataW    = 32;
    localparam int MemBeW      = 4;
    localparam int ExtMemPorts = 2;

    typedef struct packed {
        logic                we;
        logic [MemBeW-1:0]   be;
        logic [MemAddrW-1:0] addr;
        logic [MemDataW-1:0] wdata;
    } mem_req_t;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } issue_state_e;

endpackage

// File: rtl/ucup_req_fifo.sv
// rtl/ucup_req_fifo.sv - request buffer with extra-MSB pointers for full/empty detection
module ucup_req_fifo
    import ucup_mem_pkg::*;
#(
    parameter int Depth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  mem_req_t               data_i,
    input  logic                   pop_i,
    output mem_req_t               head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int AW = $clog2(Depth);

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    mem_req_t    r_mem [Depth];

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty   = (r_wptr == r_rptr);
    assign w_do_pop  = pop_i && !w_empty;
    // A full buffer still takes a push when the head leaves in the same cycle.
    assign w_do_push = push_i && (!w_full || w_do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= data_i;
    end

    assign head_o  = r_mem[r_rptr[AW-1:0]];
    assign full_o  = w_full;
    assign empty_o = w_empty;
    assign count_o = r_wptr - r_rptr;

endmodule

// File: rtl/ucup_ext_mem_bridge.sv
// rtl/ucup_ext_mem_bridge.sv - buffers SoC memory requests and issues them to one external port
module ucup_ext_mem_bridge
    import ucup_mem_pkg::*;
#(
    parameter int FifoDepth      = 4,
    parameter int MaxOutstanding = 4
) (
    input  logic        clk_sys_i,
    input  logic        rst_sys_i,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_be_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic        mem_rvalid_o,
    output logic [31:0] mem_rdata_o,
    output logic        ext_req_o,
    input  logic        ext_gnt_i,
    output logic        ext_we_o,
    output logic [3:0]  ext_be_o,
    output logic [31:0] ext_addr_o,
    output logic [31:0] ext_wdata_o,
    input  logic        ext_rvalid_i,
    input  logic [31:0] ext_rdata_i,
    output logic        overflow_o,
    output logic        spurious_o
);

    localparam int              CntW   = $clog2(FifoDepth) + 1;
    localparam logic [3:0]      MaxOut = 4'(MaxOutstanding);

    issue_state_e r_state;
    logic [3:0]   r_outstanding;
    logic         r_overflow;
    logic         r_spurious;
    logic         r_mem_rvalid;
    logic [31:0]  r_mem_rdata;

    mem_req_t        w_req_in;
    mem_req_t        w_head;
    logic            w_full;
    logic            w_empty;
    logic [CntW-1:0] w_count;
    logic            w_pop;
    logic            w_push_ok;
    logic            w_rsp;
    logic [CntW-1:0] w_cnt_next;
    logic [3:0]      w_out_next;
    logic            w_can_issue_next;

    assign w_req_in = '{we: mem_we_i, be: mem_be_i, addr: mem_addr_i, wdata: mem_wdata_i};

    ucup_req_fifo #(.Depth(FifoDepth)) u_req_fifo (
        .clk_i   (clk_sys_i),
        .rst_i   (rst_sys_i),
        .push_i  (mem_req_i),
        .data_i  (w_req_in),
        .pop_i   (w_pop),
        .head_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    assign w_pop      = ext_req_o && ext_gnt_i && !w_empty;
    assign w_push_ok  = mem_req_i && (!w_full || w_pop);
    assign w_rsp      = ext_rvalid_i && (r_outstanding != 4'd0);
    assign w_cnt_next = w_count + CntW'(w_push_ok) - CntW'(w_pop);
    assign w_out_next = r_outstanding + 4'(w_pop) - 4'(w_rsp);

    // Deciding on next-cycle occupancy keeps ext_req_o registered yet one cycle behind mem_req_i.
    assign w_can_issue_next = (w_cnt_next != '0) && (w_out_next < MaxOut);

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            r_state       <= ST_IDLE;
            r_outstanding <= 4'd0;
            r_overflow    <= 1'b0;
            r_spurious    <= 1'b0;
            r_mem_rvalid  <= 1'b0;
            r_mem_rdata   <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_can_issue_next)          r_state <= ST_ISSUE;
                ST_ISSUE: if (w_pop && !w_can_issue_next) r_state <= ST_IDLE;
                default:                                  r_state <= ST_IDLE;
            endcase
            r_outstanding <= w_out_next;
            if (mem_req_i && w_full && !w_pop)          r_overflow <= 1'b1;
            if (ext_rvalid_i && r_outstanding == 4'd0)  r_spurious <= 1'b1;
            r_mem_rvalid <= w_rsp;
            if (w_rsp) r_mem_rdata <= ext_rdata_i;
        end
    end

    // The head is only presented while requesting so idle/reset outputs read as zero.
    assign ext_req_o    = (r_state == ST_ISSUE);
    assign ext_we_o     = ext_req_o ? w_head.we    : 1'b0;
    assign ext_be_o     = ext_req_o ? w_head.be    : 4'd0;
    assign ext_addr_o   = ext_req_o ? w_head.addr  : 32'd0;
    assign ext_wdata_o  = ext_req_o ? w_head.wdata : 32'd0;
    assign mem_rvalid_o = r_mem_rvalid;
    assign mem_rdata_o  = r_mem_rdata;
    assign overflow_o   = r_overflow;
    assign spurious_o   = r_spurious;

endmodule

// File: tb/tb_ucup_ext_mem_bridge.sv
// tb/tb_ucup_ext_mem_bridge.sv - directed vector table plus multi-cycle sequences for the bridge
module tb_ucup_ext_mem_bridge;

    localparam logic [31:0] KW = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        ext_req, ext_gnt, ext_we;
    logic [3:0]  ext_be;
    logic [31:0] ext_addr, ext_wdata;
    logic        ext_rvalid;
    logic [31:0] ext_rdata;
    logic        ovf, spur;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    ucup_ext_mem_bridge #(.FifoDepth(4), .MaxOutstanding(4)) dut (
        .clk_sys_i    (clk),
        .rst_sys_i    (rst),
        .mem_req_i    (mem_req),
        .mem_we_i     (mem_we),
        .mem_be_i     (mem_be),
        .mem_addr_i   (mem_addr),
        .mem_wdata_i  (mem_wdata),
        .mem_rvalid_o (mem_rvalid),
        .mem_rdata_o  (mem_rdata),
        .ext_req_o    (ext_req),
        .ext_gnt_i    (ext_gnt),
        .ext_we_o     (ext_we),
        .ext_be_o     (ext_be),
        .ext_addr_o   (ext_addr),
        .ext_wdata_o  (ext_wdata),
        .ext_rvalid_i (ext_rvalid),
        .ext_rdata_i  (ext_rdata),
        .overflow_o   (ovf),
        .spurious_o   (spur)
    );

    typedef struct {
        logic        rst, req, we;
        logic [31:0] addr;
        logic        gnt, rv;
        logic [31:0] rdata;
        logic        e_req, e_we;
        logic [31:0] e_addr;
        logic        e_rv;
        logic [31:0] e_rdata;
        logic        e_ovf, e_spur;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst_v, logic req_v, logic we_v, logic [31:0] addr_v,
                                logic gnt_v, logic rv_v, logic [31:0] rdata_v,
                                logic e_req_v, logic e_we_v, logic [31:0] e_addr_v,
                                logic e_rv_v, logic [31:0] e_rdata_v, logic e_ovf_v, logic e_spur_v);
        vec_t v;
        v.rst = rst_v; v.req = req_v; v.we = we_v; v.addr = addr_v;
        v.gnt = gnt_v; v.rv = rv_v; v.rdata = rdata_v;
        v.e_req = e_req_v; v.e_we = e_we_v; v.e_addr = e_addr_v;
        v.e_rv = e_rv_v; v.e_rdata = e_rdata_v; v.e_ovf = e_ovf_v; v.e_spur = e_spur_v;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drv(logic r, logic req, logic we, logic [31:0] addr, logic gnt, logic rv, logic [31:0] rdata);
        rst = r; mem_req = req; mem_we = we; mem_be = req ? 4'hA : 4'h0;
        mem_addr = addr; mem_wdata = addr ^ KW;
        ext_gnt = gnt; ext_rvalid = rv; ext_rdata = rdata;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got[$];
        int rcv, sent;
        logic rv_now;

        // read, spurious, reset
        tbl.push_back(mk(0,1,0,32'h0010_0080, 0,0,0,            0,0,0,            0,0,            0,0));
        tbl.push_back(mk(0,0,0,0,             1,0,0,            1,0,32'h0010_0080, 0,0,           0,0));
        tbl.push_back(mk(0,0,0,0,             0,0,0,            0,0,0,            0,0,            0,0));
        tbl.push_back(mk(0,0,0,0,             0,1,32'hDEAD_BEEF, 0,0,0,           0,0,            0,0));
        tbl.push_back(mk(0,0,0,0,             0,0,0,            0,0,0,            1,32'hDEAD_BEEF, 0,0));
        tbl.push_back(mk(0,0,0,0,             0,0,0,            0,0,0,            0,32'hDEAD_BEEF, 0,0));
        tbl.push_back(mk(0,0,0,0,             0,1,32'h1234_5678, 0,0,0,           0,32'hDEAD_BEEF, 0,0));
        tbl.push_back(mk(0,0,0,0,             0,0,0,            0,0,0,            0,32'hDEAD_BEEF, 0,1));
        tbl.push_back(mk(1,0,0,0,             0,0,0,            0,0,0,            0,32'hDEAD_BEEF, 0,1));
        // overflow: five writes with no grant, fifth dropped
        tbl.push_back(mk(0,1,1,32'h2000_0000, 0,0,0,            0,0,0,            0,0,            0,0));
        tbl.push_back(mk(0,1,1,32'h2000_0010, 0,0,0,            1,1,32'h2000_0000, 0,0,           0,0));
        tbl.push_back(mk(0,1,1,32'h2000_0020, 0,0,0,            1,1,32'h2000_0000, 0,0,           0,0));
        tbl.push_back(mk(0,1,1,32'h2000_0030, 0,0,0,            1,1,32'h2000_0000, 0,0,           0,0));
        tbl.push_back(mk(0,1,1,32'h2000_0040, 0,0,0,            1,1,32'h2000_0000, 0,0,           0,0));
        tbl.push_back(mk(0,0,0,0,             1,0,0,            1,1,32'h2000_0000, 0,0,           1,0));
        tbl.push_back(mk(0,0,0,0,             1,0,0,            1,1,32'h2000_0010, 0,0,           1,0));
        tbl.push_back(mk(0,0,0,0,             1,0,0,            1,1,32'h2000_0020, 0,0,           1,0));
        tbl.push_back(mk(0,0,0,0,             1,0,0,            1,1,32'h2000_0030, 0,0,           1,0));
        tbl.push_back(mk(0,0,0,0,             0,1,32'hA000_0000, 0,0,0,           0,0,            1,0));
        tbl.push_back(mk(0,0,0,0,             0,1,32'hA000_0001, 0,0,0,           1,32'hA000_0000, 1,0));
        tbl.push_back(mk(0,0,0,0,             0,1,32'hA000_0002, 0,0,0,           1,32'hA000_0001, 1,0));
        tbl.push_back(mk(0,0,0,0,             0,1,32'hA000_0003, 0,0,0,           1,32'hA000_0002, 1,0));
        tbl.push_back(mk(0,0,0,0,             0,0,0,            0,0,0,            1,32'hA000_0003, 1,0));
        tbl.push_back(mk(0,0,0,0,             0,1,32'hFFFF_FFFF, 0,0,0,           0,32'hA000_0003, 1,0));
        tbl.push_back(mk(0,0,0,0,             0,0,0,            0,0,0,            0,32'hA000_0003, 1,1));
        tbl.push_back(mk(1,0,0,0,             0,0,0,            0,0,0,            0,32'hA000_0003, 1,1));

        drv(1, 0, 0, 0, 0, 0, 0);
        repeat (2) cyc();

        for (int i = 0; i < tbl.size(); i++) begin
            drv(tbl[i].rst, tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].gnt, tbl[i].rv, tbl[i].rdata);
            chk($sformatf("v%0d ext_req", i),    {31'd0, ext_req},    {31'd0, tbl[i].e_req});
            chk($sformatf("v%0d ext_we", i),     {31'd0, ext_we},     {31'd0, tbl[i].e_we});
            chk($sformatf("v%0d ext_addr", i),   ext_addr,            tbl[i].e_addr);
            chk($sformatf("v%0d ext_be", i),     {28'd0, ext_be},     tbl[i].e_req ? 32'hA : 32'h0);
            chk($sformatf("v%0d ext_wdata", i),  ext_wdata,           tbl[i].e_req ? (tbl[i].e_addr ^ KW) : 32'h0);
            chk($sformatf("v%0d mem_rvalid", i), {31'd0, mem_rvalid}, {31'd0, tbl[i].e_rv});
            chk($sformatf("v%0d mem_rdata", i),  mem_rdata,           tbl[i].e_rdata);
            chk($sformatf("v%0d overflow", i),   {31'd0, ovf},        {31'd0, tbl[i].e_ovf});
            chk($sformatf("v%0d spurious", i),   {31'd0, spur},       {31'd0, tbl[i].e_spur});
            cyc();
        end

        // burst with backpressure, then full push+pop and grant+rvalid overlap
        for (int k = 0; k < 4; k++) begin
            drv(0, 1, 1, 32'h3000_0000 + 32'(k * 4), 0, 0, 0);
            cyc();
        end
        drv(0, 0, 0, 0, 0, 0, 0);
        repeat (2) cyc();
        chk("burst full no overflow", {31'd0, ovf}, 32'd0);
        chk("burst head", ext_addr, 32'h3000_0000);
        drv(0, 1, 1, 32'h3000_0010, 1, 0, 0);
        cyc();
        chk("full push+pop no overflow", {31'd0, ovf}, 32'd0);
        got.delete(); rcv = 0; sent = 0;
        for (int i = 0; i < 16; i++) begin
            if (ext_req) got.push_back(ext_addr);
            if (mem_rvalid) begin
                chk($sformatf("burst rdata %0d", rcv), mem_rdata, 32'hD000_0000 + 32'(rcv));
                rcv++;
            end
            rv_now = (i >= 4) && (sent < 5);
            drv(0, 0, 0, 0, 1, rv_now, 32'hD000_0000 + 32'(sent));
            if (rv_now) sent++;
            cyc();
        end
        chk("burst grants", got.size(), 32'd4);
        for (int j = 0; j < got.size() && j < 4; j++)
            chk($sformatf("burst grant %0d", j), got[j], 32'h3000_0004 + 32'(j * 4));
        chk("burst responses", rcv, 32'd5);

        // outstanding limit
        drv(1, 0, 0, 0, 0, 0, 0);
        cyc();
        got.delete();
        for (int i = 0; i < 10; i++) begin
            if (ext_req) got.push_back(ext_addr);
            drv(0, i < 6, 0, 32'h4000_0000 + 32'(i * 4), 1, 0, 0);
            cyc();
        end
        chk("limit grants", got.size(), 32'd4);
        for (int j = 0; j < got.size() && j < 4; j++)
            chk($sformatf("limit grant %0d", j), got[j], 32'h4000_0000 + 32'(j * 4));
        chk("limit stalled", {31'd0, ext_req}, 32'd0);
        drv(0, 0, 0, 0, 0, 1, 32'hE000_0000);
        cyc();
        chk("limit resume req", {31'd0, ext_req}, 32'd1);
        chk("limit resume addr", ext_addr, 32'h4000_0010);
        chk("limit rvalid 0", {31'd0, mem_rvalid}, 32'd1);
        chk("limit rdata 0", mem_rdata, 32'hE000_0000);
        drv(0, 0, 0, 0, 1, 1, 32'hE000_0001);
        cyc();
        chk("gnt+rv keeps count req", {31'd0, ext_req}, 32'd1);
        chk("gnt+rv keeps count addr", ext_addr, 32'h4000_0014);
        chk("limit rdata 1", mem_rdata, 32'hE000_0001);
        drv(0, 0, 0, 0, 1, 0, 0);
        cyc();
        chk("limit drained", {31'd0, ext_req}, 32'd0);
        chk("limit rvalid idle", {31'd0, mem_rvalid}, 32'd0);

        // reset mid-burst with two queued and one in flight
        drv(1, 0, 0, 0, 0, 0, 0);
        cyc();
        drv(0, 1, 0, 32'h5000_0000, 0, 0, 0);
        cyc();
        chk("mid head 0", ext_addr, 32'h5000_0000);
        drv(0, 1, 0, 32'h5000_0004, 1, 0, 0);
        cyc();
        chk("mid head 1", ext_addr, 32'h5000_0004);
        drv(0, 1, 0, 32'h5000_0008, 0, 0, 0);
        cyc();
        drv(1, 0, 0, 0, 0, 0, 0);
        cyc();
        drv(0, 0, 0, 0, 0, 1, 32'h7777_7777);
        chk("rst ext_req", {31'd0, ext_req}, 32'd0);
        chk("rst ext_addr", ext_addr, 32'd0);
        chk("rst ext_wdata", ext_wdata, 32'd0);
        chk("rst ext_be", {28'd0, ext_be}, 32'd0);
        chk("rst ext_we", {31'd0, ext_we}, 32'd0);
        chk("rst mem_rvalid", {31'd0, mem_rvalid}, 32'd0);
        chk("rst mem_rdata", mem_rdata, 32'd0);
        chk("rst overflow", {31'd0, ovf}, 32'd0);
        chk("rst spurious", {31'd0, spur}, 32'd0);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("post-rst rvalid ignored", {31'd0, mem_rvalid}, 32'd0);
        chk("post-rst spurious", {31'd0, spur}, 32'd1);
        chk("post-rst rdata", mem_rdata, 32'd0);
        chk("post-rst fifo empty", {31'd0, ext_req}, 32'd0);
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
